// File: rtl/fifo_pkg.sv
// Shared constants for syn_fifo and its read-side controller: default geometry
// and the controller's FSM state encodings.
package fifo_pkg;

    localparam int FIFO_PTR_W = 3;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t REQ  = 2'd1;
    localparam state_t CAP  = 2'd2;

endpackage

// File: rtl/out_skid_buf.sv
// Two-entry in-order valid/ready buffer between the read FSM and the consumer.
// A push and a pop on the same edge both take effect.
module out_skid_buf #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [width-1:0] push_data_i,
    input  logic             pop_ready_i,
    output logic             pop_valid_o,
    output logic [width-1:0] pop_data_o,
    output logic [1:0]       buf_count_o
);

    logic [width-1:0] head_q, head_d;
    logic [width-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop;

    assign pop = (cnt_q != 2'd0) && pop_ready_i;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (push_i && pop) begin
            if (cnt_q == 2'd1) begin
                head_d = push_data_i;
            end else begin
                head_d = tail_q;
                tail_d = push_data_i;
            end
        end else if (push_i) begin
            if (cnt_q == 2'd0) begin
                head_d = push_data_i;
                cnt_d  = 2'd1;
            end else if (cnt_q == 2'd1) begin
                tail_d = push_data_i;
                cnt_d  = 2'd2;
            end
        end else if (pop) begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pop_valid_o = (cnt_q != 2'd0);
    assign pop_data_o  = head_q;
    assign buf_count_o = cnt_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a flagless syn_fifo: shadows occupancy from the writer's
// we, strobes re, captures the registered read data and hands it to a skid buffer.
//
// state | meaning
// IDLE  | no read in flight; waiting for data and a free buffer slot
// REQ   | re driven (held off while the writer owns the port)
// CAP   | syn_fifo read_data valid; pushed into the output buffer at the edge
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int pointer_size = FIFO_PTR_W,
    parameter int depth        = FIFO_DEPTH,
    parameter int width        = FIFO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_mon,
    output logic                  re,
    input  logic [width-1:0]      fifo_data,
    output logic [width-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [pointer_size:0] count,
    output logic                  overflow
);

    localparam logic [pointer_size:0] DEPTH_C = (pointer_size + 1)'(depth);

    state_t                state_q, state_d;
    logic [pointer_size:0] count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [1:0]            buf_count;
    logic                  in_flight;
    logic                  slot_ok;
    logic                  inc;

    // A word already requested or being captured reserves a buffer slot.
    assign in_flight = (state_q == REQ) || (state_q == CAP);
    assign slot_ok   = ({1'b0, buf_count} + {2'b00, in_flight}) < 3'd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if ((count_q != '0) && slot_ok) state_d = REQ;
            REQ:  if (!we_mon) state_d = CAP;
            CAP:  state_d = ((count_q != '0) && slot_ok) ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // syn_fifo drops re whenever we is high, so never present both.
    always_comb begin
        re = (state_q == REQ) && !we_mon;
    end

    assign inc = we_mon && (count_q != DEPTH_C);

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q | (we_mon && (count_q == DEPTH_C));
        if (inc) begin
            count_d = count_q + 1'b1;
        end else if (re) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    out_skid_buf #(
        .width(width)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (state_q == CAP),
        .push_data_i(fifo_data),
        .pop_ready_i(out_ready),
        .pop_valid_o(out_valid),
        .pop_data_o (out_data),
        .buf_count_o(buf_count)
    );

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
